// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the N-bit decoder/sequencer.
//   state_e : controller state (IDLE, DIRECT, SCAN)
//   DWELL_W : width of the scan dwell counter; large enough for DWELL 1..255
// ---------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int DWELL_W = 8;

endpackage : decoder_pkg

// File: rtl/onehot_enc_n.sv
// ---------------------------------------------------------------------------
// onehot_enc_n
// Purely combinational binary-to-one-hot converter.
//   bin_i    : N-bit binary code
//   onehot_o : 2**N-bit vector with exactly bit bin_i set
// ---------------------------------------------------------------------------
module onehot_enc_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]        bin_i,
  output logic [(1<<N)-1:0]   onehot_o
);

  // Start from all-zero and set the single selected bit.
  always_comb begin
    onehot_o        = '0;
    onehot_o[bin_i] = 1'b1;
  end

endmodule : onehot_enc_n

// File: rtl/decoder_n_seq.sv
// ---------------------------------------------------------------------------
// decoder_n_seq
// Registered N-to-2**N one-hot decoder with two operating modes:
//   direct : each accepted sel is decoded onto y one cycle later
//   scan   : y walks through every output starting at sel, holding each
//            position for DWELL cycles and wrapping modulo 2**N
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   en        : block enable, 0 parks the block in IDLE with y cleared
//   mode      : 0 = direct decode, 1 = scan
//   sel       : code to decode / scan start index
//   in_valid  : sel valid for a direct decode
//   in_ready  : direct decode can be accepted this cycle
//   y         : registered one-hot (or all-zero) output
//   out_valid : one-cycle pulse, y was loaded by an accepted direct decode
//   idx       : binary index of the asserted y bit, 0 when y is zero
//   wrap      : one-cycle pulse, scan index stepped from 2**N-1 to 0
// ---------------------------------------------------------------------------
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [(1<<N)-1:0]   y,
  output logic                out_valid,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int                 OUTS       = 1 << N;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] CNT_ONE    = DWELL_W'(1);
  localparam logic [N-1:0]       IDX_ONE    = N'(1);
  localparam logic [N-1:0]       IDX_LAST   = N'(OUTS - 1);

  state_e               state_q, state_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [OUTS-1:0]      y_q, y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wrap_q, wrap_d;

  logic                 enter_scan;
  logic                 enter_direct;
  logic                 y_load;
  logic                 y_clear;
  logic                 accept;
  logic [OUTS-1:0]      enc_y;

  // Ready depends only on the registered state plus en/mode; rst_n is
  // folded in so nothing is accepted while reset is being applied.
  assign in_ready = rst_n & en & ~mode & (state_q == DIRECT);
  assign accept   = in_valid & in_ready;

  // One encoder serves both modes: it always decodes the next index,
  // which is sel on a direct accept or scan entry, or the stepped
  // scan position when a dwell period expires.
  onehot_enc_n #(
    .N (N)
  ) u_enc (
    .bin_i    (idx_d),
    .onehot_o (enc_y)
  );

  // Next-state and output decision. The case statement only raises
  // intent flags; the shared entry actions are applied afterwards so
  // that scan entry from IDLE and from DIRECT behave identically.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    wrap_d       = 1'b0;
    y_load       = 1'b0;
    y_clear      = 1'b0;
    enter_scan   = 1'b0;
    enter_direct = 1'b0;

    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      y_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) enter_scan   = 1'b1;
          else      enter_direct = 1'b1;
        end

        DIRECT: begin
          if (mode) begin
            enter_scan = 1'b1;
          end else if (accept) begin
            idx_d       = sel;
            y_load      = 1'b1;
            out_valid_d = 1'b1;
          end
        end

        SCAN: begin
          if (!mode) begin
            enter_direct = 1'b1;
          end else if (cnt_q == DWELL_LAST) begin
            // Index arithmetic wraps naturally because OUTS is 2**N.
            cnt_d  = '0;
            idx_d  = idx_q + IDX_ONE;
            wrap_d = (idx_q == IDX_LAST);
            y_load = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          y_clear = 1'b1;
        end
      endcase

      // Scan entry shows the start position immediately rather than
      // clearing, so the first dwell period begins on the entry cycle.
      if (enter_scan) begin
        state_d = SCAN;
        idx_d   = sel;
        cnt_d   = '0;
        y_load  = 1'b1;
      end

      if (enter_direct) begin
        state_d = DIRECT;
        idx_d   = '0;
        cnt_d   = '0;
        y_clear = 1'b1;
      end
    end

    if (y_clear)     y_d = '0;
    else if (y_load) y_d = enc_y;
    else             y_d = y_q;
  end

  // State and output registers; every output is taken straight from a
  // flop so no input has a combinational path to y/idx/out_valid/wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign y         = y_q;
  assign idx       = idx_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule : decoder_n_seq

// File: tb/tb_decoder_n_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_n_seq
// Drives two instances from the same stimulus: the default build
// (N=3, DWELL=4) and the corner build (N=1, DWELL=1). A behavioural
// model predicts each instance's registered outputs; predictions are
// queued by the driver and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_decoder_n_seq;

  localparam int N      = 3;
  localparam int DWELL  = 4;
  localparam int N2     = 1;
  localparam int DWELL2 = 1;

  localparam int PH_IDLE   = 0;
  localparam int PH_DIRECT = 1;
  localparam int PH_SCAN   = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         mode;
  logic [2:0]   sel;
  logic         inValid;

  logic         inReady;
  logic [7:0]   y;
  logic         outValid;
  logic [2:0]   idx;
  logic         wrap;

  logic         inReady2;
  logic [1:0]   y2;
  logic         outValid2;
  logic [0:0]   idx2;
  logic         wrap2;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       ov;
    logic       wrap;
  } expect_t;

  expect_t q0[$];
  expect_t q1[$];

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state per instance: which mode the block is in, where the
  // current scan started and how many cycles it has been running, and
  // the value direct mode is holding.
  int mPhase[2];
  int mStart[2];
  int mElapsed[2];
  int mY[2];
  int mIdx[2];

  always #5 clk = ~clk;

  decoder_n_seq #(.N(N), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .y         (y),
    .out_valid (outValid),
    .idx       (idx),
    .wrap      (wrap)
  );

  decoder_n_seq #(.N(N2), .DWELL(DWELL2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel[0:0]),
    .in_valid  (inValid),
    .in_ready  (inReady2),
    .y         (y2),
    .out_valid (outValid2),
    .idx       (idx2),
    .wrap      (wrap2)
  );

  // Ready is a function of the inputs and the mode the block is in now.
  function automatic bit expReady(input int k, input bit rstN, input bit enI,
                                  input bit modeI);
    return rstN && enI && !modeI && (mPhase[k] == PH_DIRECT);
  endfunction

  // Advance the model across one rising edge and return the outputs
  // that should be visible after it. Scan position is derived from the
  // elapsed cycle count rather than from a dwell counter.
  function automatic expect_t modelStep(input int k, input int n, input int dwell,
                                        input bit rstN, input bit enI,
                                        input bit modeI, input bit validI,
                                        input int selI);
    expect_t e;
    int      outs;
    int      cur;
    outs   = 1 << n;
    e.ov   = 1'b0;
    e.wrap = 1'b0;
    if (!rstN || !enI) begin
      mPhase[k] = PH_IDLE;
      mY[k]     = 0;
      mIdx[k]   = 0;
    end else if (modeI) begin
      if (mPhase[k] != PH_SCAN) begin
        mPhase[k]   = PH_SCAN;
        mStart[k]   = selI;
        mElapsed[k] = 0;
      end else begin
        mElapsed[k] = mElapsed[k] + 1;
      end
      cur    = (mStart[k] + mElapsed[k] / dwell) % outs;
      e.wrap = (mElapsed[k] > 0) && (mElapsed[k] % dwell == 0) && (cur == 0);
      mY[k]   = 1 << cur;
      mIdx[k] = cur;
    end else begin
      if (mPhase[k] != PH_DIRECT) begin
        mPhase[k] = PH_DIRECT;
        mY[k]     = 0;
        mIdx[k]   = 0;
      end else if (validI) begin
        mY[k]   = 1 << selI;
        mIdx[k] = selI;
        e.ov    = 1'b1;
      end
    end
    e.y   = 8'(mY[k]);
    e.idx = 3'(mIdx[k]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check the combinational ready against the
  // model, then queue the predicted post-edge outputs of both instances.
  task automatic applyStimulus(input bit r, input bit e, input bit m, input bit v,
                               input logic [2:0] s);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    mode    = m;
    inValid = v;
    sel     = s;
    #1;
    checkOutput("in_ready", int'(inReady), int'(expReady(0, r, e, m)));
    checkOutput("in_ready2", int'(inReady2), int'(expReady(1, r, e, m)));
    q0.push_back(modelStep(0, N, DWELL, r, e, m, v, int'(s)));
    q1.push_back(modelStep(1, N2, DWELL2, r, e, m, v, int'(s[0])));
  endtask

  function automatic bit idxAgrees8(input logic [7:0] yv, input logic [2:0] iv);
    if (yv == 8'd0) return (iv == 3'd0);
    return (yv == (8'd1 << iv));
  endfunction

  function automatic bit idxAgrees2(input logic [1:0] yv, input logic [0:0] iv);
    if (yv == 2'd0) return (iv == 1'b0);
    return (yv == (2'd1 << iv));
  endfunction

  // Monitor: one edge after each queued prediction, compare everything
  // the DUT shows and check the one-hot/index invariants.
  always @(posedge clk) begin : monitor
    expect_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput("y", int'(y), int'(e.y));
      checkOutput("idx", int'(idx), int'(e.idx));
      checkOutput("out_valid", int'(outValid), int'(e.ov));
      checkOutput("wrap", int'(wrap), int'(e.wrap));
      checkOutput("y_onehot0", int'($onehot0(y)), 1);
      checkOutput("idx_vs_y", int'(idxAgrees8(y, idx)), 1);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("y2", int'(y2), int'(e.y));
      checkOutput("idx2", int'(idx2), int'(e.idx));
      checkOutput("out_valid2", int'(outValid2), int'(e.ov));
      checkOutput("wrap2", int'(wrap2), int'(e.wrap));
      checkOutput("y2_onehot0", int'($onehot0(y2)), 1);
      checkOutput("idx2_vs_y2", int'(idxAgrees2(y2, idx2)), 1);
    end
  end

  initial begin
    bit          curMode;
    bit          curEn;
    bit          curRst;
    logic [2:0]  rs;

    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    inValid = 1'b0;
    sel     = 3'd0;
    for (int k = 0; k < 2; k++) begin
      mPhase[k] = PH_IDLE; mStart[k] = 0; mElapsed[k] = 0; mY[k] = 0; mIdx[k] = 0;
    end

    // Power-on reset, then idle with en low.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Direct: enter, then back-to-back accepts of 5 and 2, then hold.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd7);

    // Scan from 6 long enough to wrap and move past 0.
    repeat (14) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd6);

    // Leave scan via IDLE, rescan from 3 with in_valid high, then switch
    // to direct while in_valid stays high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd4);

    // Reset for three cycles in the middle of a scan, release with en low.
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Scan from 1 (corner build alternates and wraps every other cycle),
    // then drop en mid-dwell.
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd1);

    // Randomised run with occasional reset, enable drops and mode flips.
    curMode = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(15) == 0) curMode = ~curMode;
      curEn  = ($urandom_range(19) != 0);
      curRst = ($urandom_range(199) != 0);
      rs     = 3'($urandom_range(7));
      applyStimulus(curRst, curEn, curMode, 1'($urandom_range(1)), rs);
    end

    // Let the monitor drain the last predictions.
    repeat (2) @(negedge clk);
    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_decoder_n_seq

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 Parameter N, default 3: select width; one-hot output width is OUTS = 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 4: cycles per output in scan mode; legal range 1..255.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port en, input, 1: block enable; 0 forces IDLE.
REQ-006 Port mode, input, 1: 0 = direct decode, 1 = scan.
REQ-007 Port sel, input, N: code to decode (direct mode) or scan start index (scan entry).
REQ-008 Port in_valid, input, 1: sel valid for direct decode.
REQ-009 Port in_ready, output, 1: block accepts sel this cycle.
REQ-010 Port y, output, OUTS: registered one-hot (or all-zero) decode output.
REQ-011 Port out_valid, output, 1: one-cycle pulse, y updated by an accepted direct decode.
REQ-012 Port idx, output, N: binary index of the asserted y bit; 0 when y is all-zero.
REQ-013 Port wrap, output, 1: one-cycle pulse, scan index stepped from OUTS-1 to 0.

Function
REQ-014 The FSM shall have exactly three states: IDLE, DIRECT, SCAN.
REQ-015 From any state, en=0 shall move to IDLE next cycle; IDLE forces y=0, idx=0.
REQ-016 IDLE with en=1, mode=0 shall move to DIRECT; en=1, mode=1 shall move to SCAN.
REQ-017 DIRECT with en=1, mode=1 shall move to SCAN; SCAN with en=1, mode=0 shall move to DIRECT.
REQ-018 Every state change shall clear y to 0 and idx to 0 in the cycle the new state is entered, except SCAN entry (REQ-022).
REQ-019 in_ready shall be 1 only in DIRECT with en=1, mode=0; 0 otherwise.
REQ-020 Accept = in_valid & in_ready; on accept y shall equal 1<<sel, idx=sel, and out_valid=1 on the following cycle (latency 1).
REQ-021 In DIRECT, y/idx shall hold the last accepted value until the next accept or a state exit; out_valid=0 with no accept.
REQ-022 SCAN entry shall latch sel as start index; y=1<<sel on the first SCAN cycle.
REQ-023 In SCAN, a dwell counter shall hold each index for exactly DWELL cycles, then index increments modulo OUTS and the counter restarts.
REQ-024 Index step OUTS-1 -> 0 shall pulse wrap for exactly the cycle y first shows bit 0.
REQ-025 DWELL=1 shall advance every cycle; N=1 shall alternate y between 01 and 10.
REQ-026 in_valid outside DIRECT shall be ignored; no out_valid, no state effect.
REQ-027 y shall never have more than one bit set in any cycle.
REQ-028 Combinational paths from inputs to y, idx, out_valid or wrap are forbidden; in_ready may depend combinationally on en/mode only.

Reset
REQ-029 rst_n=0 at a rising edge shall force IDLE, y=0, idx=0, out_valid=0, wrap=0, dwell counter=0, index=0, regardless of state, including mid-scan or mid-accept.
REQ-030 in_ready shall be 0 while rst_n=0; first accept possible on the first edge after rst_n returns 1 in DIRECT.

Structure
REQ-031 A shared package decoder_pkg shall hold the state enum (IDLE, DIRECT, SCAN) and constant DWELL_W = 8.
REQ-032 One sub-module, onehot_enc_n (parameter N: binary in, one-hot out, combinational), shall be instantiated for both modes.
REQ-033 FSM, dwell counter and index register shall be in decoder_n_seq; no other sub-modules.

Verification (N=3, DWELL=4 unless stated)
REQ-034 Reset: rst_n=0 3 cycles mid-SCAN -> y=0, idx=0, wrap=0, in_ready=0; FSM IDLE after release with en=0.
REQ-035 Direct: en=1, mode=0, accepts sel=5 then sel=2 back-to-back -> y=0x20, then 0x04 on consecutive cycles; out_valid high both cycles; idx 5 then 2.
REQ-036 Scan: en=1, mode=1, sel=6 -> y=0x40 4 cycles, 0x80 4 cycles, 0x01 with wrap=1 for one cycle, then 0x02.
REQ-037 Mode switch mid-scan at y=0x08 -> next cycle y=0, in_ready=1; in_valid ignored before the switch gives no out_valid.
REQ-038 Corners: DWELL=1, N=1 scan from sel=1 -> y 10,01(wrap),10,01(wrap)...; en dropped mid-dwell -> y=0 next cycle.
REQ-039 Random run of 10k cycles with an assertion that y is one-hot-or-zero and idx matches y every cycle.
